// File: rtl/pcie_regfile_if.sv
// CPU-side read/write channel of the PCIe register file.
// The CPU drives requests and write data; the register file answers with ready and read data.
interface pcie_regfile_if #(
  parameter int REG_ABITS = 3
);
  logic [REG_ABITS-1:0] cpuChan_in;
  logic [31:0]          cpuWrData_in;
  logic                 cpuWrValid_in;
  logic                 cpuWrReady_out;
  logic                 cpuRdReq_in;
  logic                 cpuRdReqReady_out;
  logic [31:0]          cpuRdData_out;
  logic                 cpuRdValid_out;
  logic                 cpuRdReady_in;

  modport master (
    output cpuChan_in, cpuWrData_in, cpuWrValid_in, cpuRdReq_in, cpuRdReady_in,
    input  cpuWrReady_out, cpuRdReqReady_out, cpuRdData_out, cpuRdValid_out
  );

  modport slave (
    input  cpuChan_in, cpuWrData_in, cpuWrValid_in, cpuRdReq_in, cpuRdReady_in,
    output cpuWrReady_out, cpuRdReqReady_out, cpuRdData_out, cpuRdValid_out
  );
endinterface

// File: rtl/pcie_regfile.sv
// Parametrised CSR file with RW / RO / W1C / PULSE registers, registered reads
// under a valid/ready handshake and single-cycle writes.
module pcie_regfile #(
  parameter int                                REG_ABITS   = 3,
  parameter int                                SWAP_MODE   = 0,
  parameter logic [(1<<REG_ABITS)-1:0]         RO_MASK     = '0,
  parameter logic [(1<<REG_ABITS)-1:0]         W1C_MASK    = '0,
  parameter logic [(1<<REG_ABITS)-1:0]         PULSE_MASK  = '0,
  parameter logic [32*(1<<REG_ABITS)-1:0]      INIT_VALUES = '0
) (
  input  logic                                 pcieClk_in,
  input  logic                                 reset_in,
  pcie_regfile_if.slave                        cpu,
  output logic [32*(1<<REG_ABITS)-1:0]         hwRegs_out,
  output logic [(1<<REG_ABITS)-1:0]            hwWrStrobe_out,
  input  logic [32*(1<<REG_ABITS)-1:0]         hwStatus_in,
  input  logic [32*(1<<REG_ABITS)-1:0]         hwEvent_in
);
  localparam int NREGS = 1 << REG_ABITS;

  typedef enum logic [1:0] {MODE_RW, MODE_RO, MODE_W1C, MODE_PULSE} reg_mode_e;

  // Overlapping masks resolve as RO > W1C > PULSE.
  function automatic reg_mode_e mode_of(input int idx);
    if (RO_MASK[idx])    return MODE_RO;
    if (W1C_MASK[idx])   return MODE_W1C;
    if (PULSE_MASK[idx]) return MODE_PULSE;
    return MODE_RW;
  endfunction

  function automatic logic [31:0] swap(input logic [31:0] d);
    case (SWAP_MODE)
      1:       return {d[15:0], d[31:16]};
      2:       return {d[7:0], d[15:8], d[23:16], d[31:24]};
      default: return d;
    endcase
  endfunction

  logic [31:0]      regs_q [NREGS];
  logic [31:0]      regs_d [NREGS];
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [NREGS-1:0] strobe_q, strobe_d;
  logic [31:0]      rd_word;
  logic             wr_fire, rd_fire;

  assign cpu.cpuWrReady_out    = !reset_in;
  assign cpu.cpuRdReqReady_out = !reset_in & (!rd_valid_q | cpu.cpuRdReady_in);
  assign cpu.cpuRdData_out     = rd_data_q;
  assign cpu.cpuRdValid_out    = rd_valid_q;
  assign hwWrStrobe_out        = strobe_q;

  assign wr_fire = cpu.cpuWrValid_in & cpu.cpuWrReady_out;
  assign rd_fire = cpu.cpuRdReq_in & cpu.cpuRdReqReady_out;

  // Reads sample the pre-write state, so a same-edge write is never bypassed.
  assign rd_word = RO_MASK[cpu.cpuChan_in] ? hwStatus_in[32*cpu.cpuChan_in +: 32]
                                           : regs_q[cpu.cpuChan_in];

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREGS; i++) begin
      logic [31:0] wmask;
      wmask = (wr_fire && cpu.cpuChan_in == REG_ABITS'(i)) ? cpu.cpuWrData_in : 32'h0;
      case (mode_of(i))
        MODE_RO:    regs_d[i] = 32'h0;
        MODE_W1C:   regs_d[i] = (regs_q[i] & ~wmask) | hwEvent_in[32*i +: 32];
        MODE_PULSE: regs_d[i] = wmask;
        default:    if (wr_fire && cpu.cpuChan_in == REG_ABITS'(i)) regs_d[i] = cpu.cpuWrData_in;
      endcase
    end

    strobe_d = '0;
    if (wr_fire) strobe_d[cpu.cpuChan_in] = 1'b1;

    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    if (rd_fire) begin
      rd_valid_d = 1'b1;
      rd_data_d  = swap(rd_word);
    end else if (cpu.cpuRdReady_in) begin
      rd_valid_d = 1'b0;
    end
  end

  always_comb begin
    hwRegs_out = '0;
    for (int i = 0; i < NREGS; i++)
      hwRegs_out[32*i +: 32] = RO_MASK[i] ? hwStatus_in[32*i +: 32] : regs_q[i];
  end

  // NOTE: the register array is a handful of flops with defined reset values, so it is reset explicitly, unlike a RAM.
  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= (mode_of(i) == MODE_RW) ? INIT_VALUES[32*i +: 32] : 32'h0;
      rd_data_q  <= 32'h0;
      rd_valid_q <= 1'b0;
      strobe_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      regs_q     <= regs_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      strobe_q   <= strobe_d;
    end
  end

  always_ff @(posedge pcieClk_in) begin
    assert ((RO_MASK & W1C_MASK) == '0 && (RO_MASK & PULSE_MASK) == '0 &&
            (W1C_MASK & PULSE_MASK) == '0)
      else $error("pcie_regfile: overlapping register mode masks");
  end
endmodule

// File: doc/pcie_regfile.md
Name: pcie_regfile

Overview:
- Parametrised control/status register file on the internal CPU read/write channel of the PCIe TLP transceiver, clocked by pcieClk_in.
- Next generation of the flat pcie-regs register array. Register count, initial values and per-register access mode are parameters. Read-data swap is configurable.
- Reads are registered and held under a valid/ready handshake. Writes are single-cycle.
- Exposes register contents, per-register write strobes and hardware status/event inputs to user logic.

Parameters:
- REG_ABITS, 3, register address width; NREGS = 2**REG_ABITS.
- SWAP_MODE, 0, read-data swap: 0 none, 1 swap 16-bit halves, 2 full byte reverse.
- RO_MASK, '0, NREGS bits; bit i=1 makes reg i read-only, reading hwStatus_in word i.
- W1C_MASK, '0, NREGS bits; bit i=1 makes reg i sticky-event: hwEvent_in sets bits, CPU writing 1 clears bits.
- PULSE_MASK, '0, NREGS bits; bit i=1 makes reg i self-clearing: a written value is visible on hwRegs_out for exactly one cycle.
- INIT_VALUES, '0, NREGS*32 bits; reset value of each RW reg, word i at [32*i+:32].

Ports:
- pcieClk_in  in  1  125MHz PCIe clock
- reset_in  in  1  synchronous active-high reset
- cpuChan_in  in  REG_ABITS  register index for the current write or read request
- cpuWrData_in  in  32  write data
- cpuWrValid_in  in  1  write request
- cpuWrReady_out  out  1  write accepted
- cpuRdReq_in  in  1  read request, qualified by cpuRdReqReady_out
- cpuRdReqReady_out  out  1  read slot free
- cpuRdData_out  out  32  read data, post-swap
- cpuRdValid_out  out  1  read data valid
- cpuRdReady_in  in  1  consumer takes read data
- hwRegs_out  out  NREGS*32  current register contents; word i at [32*i+:32]
- hwWrStrobe_out  out  NREGS  one-cycle pulse, reg i written by CPU the previous cycle
- hwStatus_in  in  NREGS*32  values for RO regs
- hwEvent_in  in  NREGS*32  set pulses for W1C regs

Behaviour:
- Reset (reset_in high at a clock edge):
  - RW regs load INIT_VALUES.
  - W1C and PULSE regs load 0.
  - cpuRdValid_out=0, cpuRdData_out=0, hwWrStrobe_out=0.
  - cpuWrReady_out=0 and cpuRdReqReady_out=0 during any cycle where reset_in=1.
  - Reset mid-read discards the pending read.
- Write:
  - Accepted on any edge with cpuWrValid_in & cpuWrReady_out.
  - cpuWrReady_out = !reset_in, so there is no backpressure outside reset.
  - Takes effect at that edge. hwWrStrobe_out[chan] pulses the following cycle.
- Write effect by register mode:
  - RW: reg <= data.
  - RO: no storage change. Strobe still pulses.
  - W1C: reg <= (reg & ~data) | event. A bit set by hwEvent_in in the same cycle wins over the clear.
  - PULSE: reg <= data for one cycle, then returns to 0. A back-to-back write re-loads the register.
- W1C event accumulation: every cycle, reg |= hwEvent_in word, independent of CPU activity.
- Read handshake:
  - cpuRdReqReady_out = !reset_in & (!cpuRdValid_out | cpuRdReady_in).
  - Request accepted at an edge with cpuRdReq_in & cpuRdReqReady_out. The next cycle has cpuRdValid_out=1 and data captured at the accepting edge. Latency is 1.
  - Captured data for RO regs is hwStatus_in at the accepting edge.
  - Data and valid are held stable until an edge with cpuRdReady_in=1.
  - Back-to-back reads sustain one per cycle when cpuRdReady_in=1.
  - A request with cpuRdReqReady_out=0 is not accepted. The requester holds it.
- Read/write collision, same edge, same register: read returns the pre-write value. Read-before-write ordering, no bypass.
- Swap:
  - Applied to read data only.
  - SWAP_MODE=1: {d[15:0],d[31:16]}.
  - SWAP_MODE=2: {d[7:0],d[15:8],d[23:16],d[31:24]}.
  - hwRegs_out is never swapped.
- Masks:
  - Overlapping mask bits are illegal and must trigger a simulation assertion.
  - Precedence if synthesised anyway: RO > W1C > PULSE.
- cpuChan_in covers all NREGS, so there are no out-of-range addresses.

Test Plan:
- Reset with INIT_VALUES word 2 = 0xCAFE0001, all masks 0 -> read reg 2 returns 0xCAFE0001 one cycle after request. hwRegs_out word 2 = 0xCAFE0001. All strobes 0.
- SWAP_MODE=2: write 0x11223344 to reg 5, then read -> cpuRdData_out = 0x44332211. hwRegs_out word 5 = 0x11223344. hwWrStrobe_out = 8'h20 for one cycle.
- W1C reg 1: hwEvent pulses 0x0000000F, then CPU writes 0x00000005 while hwEvent = 0x00000001 the same cycle -> reg = 0x0000000B.
- Read backpressure: request reg 3 (RO, hwStatus=0xA5A5A5A5), hold cpuRdReady_in=0 for 4 cycles while hwStatus changes to 0 -> data stays 0xA5A5A5A5, valid stays high, cpuRdReqReady_out=0. Releasing ready completes the transfer.
- PULSE reg 4: write 0x80000000 -> hwRegs_out word 4 = 0x80000000 for exactly one cycle, then 0. A subsequent read returns 0.
- Reset asserted while cpuRdValid_out=1 -> valid drops at the next edge. Ready outputs are 0 during reset. All registers return to their reset values.
